// File: rtl/lamp_ramp_ctrl.sv
// Lamp-bank controller: thermometer-coded lamp vector with soft ramp.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   target_valid   : load target_count (clamped to N_LAMPS) this cycle
//   target_count   : requested number of lit lamps
//   mode           : 0 = ramp one lamp per STEP_CYCLES, 1 = immediate
//   force_off      : emergency off, overrides everything
//   lights_state   : lamp i on iff i < current_count
//   current_count  : registered number of lit lamps
//   busy           : high while ramping
//   done           : one-cycle pulse when current_count reaches target
module lamp_ramp_ctrl #(
  parameter int N_LAMPS     = 16,
  parameter int CNT_W       = $clog2(N_LAMPS + 1),
  parameter int STEP_CYCLES = 1000,
  parameter int STEP_W      = $clog2(STEP_CYCLES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               target_valid,
  input  logic [CNT_W-1:0]   target_count,
  input  logic               mode,
  input  logic               force_off,
  output logic [N_LAMPS-1:0] lights_state,
  output logic [CNT_W-1:0]   current_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(N_LAMPS);
  localparam logic [STEP_W-1:0] LAST_TICK =
    STEP_W'(STEP_CYCLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  target_d;
  logic [STEP_W-1:0] timer_q;
  logic [STEP_W-1:0] timer_d;
  logic              done_q;
  logic              done_d;

  logic [CNT_W-1:0]  tgt;
  logic [CNT_W-1:0]  step_cnt;
  logic              tick;

  // Requests above the bank size saturate at all lamps on.
  assign tgt = (target_count > MAX_CNT) ?
    MAX_CNT : target_count;

  assign tick = (timer_q == LAST_TICK);

  // Ramp direction is fixed by the state; the
  // target is never passed, so no wrap guard is
  // needed beyond the state itself.
  always_comb begin
    step_cnt = count_q;
    unique case (state_q)
      RAMP_UP: begin
        if (count_q < MAX_CNT)
          step_cnt = count_q + CNT_W'(1);
      end
      RAMP_DOWN: begin
        if (count_q != '0)
          step_cnt = count_q - CNT_W'(1);
      end
      default: step_cnt = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      timer_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    if (force_off) begin
      state_d  = IDLE;
      count_d  = '0;
      target_d = '0;
      timer_d  = '0;
    end else if (target_valid) begin
      target_d = tgt;
      timer_d  = '0;
      if (mode) begin
        count_d = tgt;
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (tgt > count_q) begin
        state_d = RAMP_UP;
      end else if (tgt < count_q) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (state_q != IDLE) begin
      if (tick) begin
        timer_d = '0;
        count_d = step_cnt;
        if (step_cnt == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        timer_d = timer_q + STEP_W'(1);
      end
    end
  end

  // Thermometer decode straight off the count
  // register, so lamps track it with no delay.
  for (genvar g = 0; g < N_LAMPS; g++) begin : g_lamp
    assign lights_state[g] =
      (count_q > CNT_W'(g));
  end

  assign current_count = count_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
